// File: rtl/scdaq_pkg.sv
// Shared definitions for the single-channel DAQ acquisition path: sequencer
// state encodings, trigger-mode constants and a capture-state helper.
package scdaq_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRETRIG = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_POST    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Trigger-mode encodings, kept in step with the trigger processor.
  typedef enum logic [1:0] {
    TRG_EDGE_RISE = 2'd0,
    TRG_EDGE_FALL = 2'd1,
    TRG_LEVEL     = 2'd2,
    TRG_WINDOW    = 2'd3
  } trg_mode_e;

  function automatic logic is_capture(input logic [2:0] st);
    return (st == ST_PRETRIG) || (st == ST_ARMED) || (st == ST_POST);
  endfunction

endpackage

// File: rtl/scdaq_acq_cnt.sv
// Loadable down-counter with a zero flag; used for the pre/post sample
// counts and, when enabled, the auto-trigger timeout.
module scdaq_acq_cnt #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scdaq_acq_ctrl.sv
// Acquisition sequencer: arm, pre-trigger fill, wait for trigger, post-trigger
// capture into a circular buffer. Optional forced trigger: SCDAQ_AUTO_TRIGGER_EN.
module scdaq_acq_ctrl
  import scdaq_pkg::*;
#(
  parameter int unsigned PRECISION    = 8,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned AUTO_TIMEOUT = 1024
) (
  input  logic                  DAQ_Clock,
  input  logic                  Reset_n,
  input  logic [PRECISION-1:0]  DAQ_Q,
  input  logic                  DAQ_Trg,
  input  logic [ADDR_WIDTH-1:0] CFG_PRE,
  input  logic [ADDR_WIDTH-1:0] CFG_POST,
  input  logic                  CFG_SINGLE,
  input  logic                  CMD_Arm,
  input  logic                  CMD_Abort,
  input  logic                  ACQ_Ack,
  output logic                  BUF_We,
  output logic [ADDR_WIDTH-1:0] BUF_Addr,
  output logic [PRECISION-1:0]  BUF_D,
  output logic [ADDR_WIDTH-1:0] ACQ_TrgAddr,
  output logic                  ACQ_Done,
  output logic                  ACQ_Auto,
  output logic [2:0]            ACQ_State
);

  if (AUTO_TIMEOUT == 0) begin : g_bad_timeout
    $error("AUTO_TIMEOUT must be nonzero");
  end

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, pre_q, post_q, trg_addr_q, addr_q;
  logic [PRECISION-1:0]  d_q;
  logic                  single_q, we_q, done_q;
  logic                  trig, auto_fire, capture;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [ADDR_WIDTH-1:0] arm_pre, cnt_val;

  assign capture = is_capture(state_q) && !CMD_Abort;
  assign arm_pre = (state_q == ST_IDLE) ? CFG_PRE : pre_q;

  always_comb begin
    state_d = state_q;
    trig    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_Arm) begin
          state_d = (CFG_PRE == '0) ? ST_ARMED : ST_PRETRIG;
        end
      end
      ST_PRETRIG: begin
        if (cnt_zero) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (DAQ_Trg || auto_fire) begin
          trig    = 1'b1;
          state_d = (post_q == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (cnt_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ACQ_Ack) begin
          if (single_q) state_d = ST_IDLE;
          else          state_d = (pre_q == '0) ? ST_ARMED : ST_PRETRIG;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over arm, trigger and ack on the same edge.
    if (CMD_Abort) begin
      state_d = ST_IDLE;
      trig    = 1'b0;
    end
  end

  // Counter holds "writes remaining minus one" so the zero flag marks the last write edge.
  assign cnt_load = (state_d != state_q);
  assign cnt_val  = (state_d == ST_PRETRIG) ? (arm_pre - ADDR_WIDTH'(1))
                                            : (post_q - ADDR_WIDTH'(1));
  assign cnt_dec  = !cnt_load && ((state_q == ST_PRETRIG) || (state_q == ST_POST));

  scdaq_acq_cnt #(
    .WIDTH(ADDR_WIDTH)
  ) u_len_cnt (
    .clk_i      (DAQ_Clock),
    .rst_ni     (Reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifdef SCDAQ_AUTO_TRIGGER_EN
  localparam int unsigned TO_W = ($clog2(AUTO_TIMEOUT) < 1) ? 1 : $clog2(AUTO_TIMEOUT);

  logic to_load, to_zero, auto_q;

  assign to_load = (state_d == ST_ARMED) && (state_q != ST_ARMED);

  scdaq_acq_cnt #(
    .WIDTH(TO_W)
  ) u_to_cnt (
    .clk_i      (DAQ_Clock),
    .rst_ni     (Reset_n),
    .load_i     (to_load),
    .load_val_i (TO_W'(AUTO_TIMEOUT - 1)),
    .dec_i      (state_q == ST_ARMED),
    .zero_o     (to_zero)
  );

  assign auto_fire = (state_q == ST_ARMED) && to_zero;

  // A real trigger arriving on the timeout edge still counts as real.
  always_ff @(posedge DAQ_Clock) begin
    if (!Reset_n) begin
      auto_q <= 1'b0;
    end else if (trig) begin
      auto_q <= !DAQ_Trg;
    end
  end

  assign ACQ_Auto = auto_q;
`else
  assign auto_fire = 1'b0;
  assign ACQ_Auto  = 1'b0;
`endif

  always_ff @(posedge DAQ_Clock) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      single_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      d_q        <= '0;
      trg_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && CMD_Arm && !CMD_Abort) begin
        pre_q    <= CFG_PRE;
        post_q   <= CFG_POST;
        single_q <= CFG_SINGLE;
      end
      we_q <= capture;
      if (capture) begin
        d_q    <= DAQ_Q;
        addr_q <= wptr_q;
        wptr_q <= wptr_q + ADDR_WIDTH'(1);
      end
      if (trig) begin
        trg_addr_q <= wptr_q;
      end
      // Done follows the DONE state by one edge and drops on ack or abort.
      done_q <= (state_q == ST_DONE) && !ACQ_Ack && !CMD_Abort;
    end
  end

  assign BUF_We      = we_q;
  assign BUF_Addr    = addr_q;
  assign BUF_D       = d_q;
  assign ACQ_TrgAddr = trg_addr_q;
  assign ACQ_Done    = done_q;
  assign ACQ_State   = state_q;

endmodule

// File: doc/scdaq_acq_ctrl.md
# scdaq_acq_ctrl

Acquisition sequencer for the single-channel DAQ path. It sits between the trigger processor's sample/trigger outputs (`DAQ_Q`, `DAQ_Trg`) and a single-port capture RAM. It runs arm → pre-trigger fill → wait-for-trigger → post-trigger capture → done/handshake into a circular buffer, and reports the trigger sample's address to the readout side. Single-shot and continuous re-arm are supported.

## Interface
- `PRECISION`, 8, sample width in bits
- `ADDR_WIDTH`, 10, capture buffer address width; depth = 2^`ADDR_WIDTH`
- `AUTO_TIMEOUT`, 1024, ARMED cycles before forced trigger; used only with the macro
- `DAQ_Clock`  in  1  sampling clock; one clock domain
- `Reset_n`  in  1  reset, synchronous, active-low
- `DAQ_Q`  in  `PRECISION`  sample stream from the trigger processor
- `DAQ_Trg`  in  1  trigger qualifier from the trigger processor
- `CFG_PRE`  in  `ADDR_WIDTH`  pre-trigger sample count
- `CFG_POST`  in  `ADDR_WIDTH`  post-trigger sample count
- `CFG_SINGLE`  in  1  1 = single-shot, 0 = re-arm after ack
- `CMD_Arm`  in  1  start pulse
- `CMD_Abort`  in  1  abort pulse
- `ACQ_Ack`  in  1  readout finished
- `BUF_We`  out  1  buffer write enable
- `BUF_Addr`  out  `ADDR_WIDTH`  buffer write address
- `BUF_D`  out  `PRECISION`  buffer write data
- `ACQ_TrgAddr`  out  `ADDR_WIDTH`  address of the trigger sample
- `ACQ_Done`  out  1  capture complete, level
- `ACQ_Auto`  out  1  last capture was auto-triggered
- `ACQ_State`  out  3  state encoding

## Operation
- States: IDLE=0, PRETRIG=1, ARMED=2, POST=3, DONE=4.
- Capture states are PRETRIG, ARMED and POST. On every edge whose pre-edge state is a capture state:
  - `BUF_D`<=`DAQ_Q`, `BUF_Addr`<=wptr, `BUF_We`<=1, wptr<=wptr+1 (mod 2^`ADDR_WIDTH`).
  - On all other edges, `BUF_We`<=0.
- IDLE: `CMD_Arm` latches `CFG_PRE`, `CFG_POST` and `CFG_SINGLE`, then goes to PRETRIG. If `CFG_PRE`=0, it goes directly to ARMED.
- PRETRIG: makes exactly `CFG_PRE` writes, then ARMED. `DAQ_Trg` is ignored here.
- ARMED: writes continuously, overwriting circularly. An edge that samples `DAQ_Trg`=1 is the trigger edge:
  - That edge's write address goes to `ACQ_TrgAddr`.
  - Next state is POST, or DONE if `CFG_POST`=0.
- POST: makes exactly `CFG_POST` further writes, then DONE.
- DONE: `ACQ_Done`=1 and no writes. On `ACQ_Ack`:
  - latched single=1 → IDLE;
  - otherwise → PRETRIG with the latched config and wptr continuing.
- `CMD_Abort`: from any state → IDLE on the next edge. Effects:
  - `BUF_We`=0, `ACQ_Done`=0, `ACQ_TrgAddr` unchanged.
  - Abort beats `CMD_Arm`, trigger and `ACQ_Ack` when they coincide.
- `CMD_Arm` is ignored outside IDLE; `ACQ_Ack` is ignored outside DONE.
- `CFG_PRE`+`CFG_POST` ≥ 2^`ADDR_WIDTH` is legal; the oldest pre-trigger samples are overwritten. There is no check.

## Timing
- Reset is synchronous: state IDLE, wptr 0, and every output 0.
- Reset has priority over every input, including mid-capture.
- Write latency: `DAQ_Q` sampled at edge n appears on `BUF_D` during cycle n+1, with `BUF_We`/`BUF_Addr` aligned.
- Arm-to-first-write: `CMD_Arm` sampled at edge 0 → state PRETRIG after edge 0 → first `BUF_We`=1 after edge 1.
- `ACQ_Done` rises on the edge after the last POST write edge. It falls on the edge that samples `ACQ_Ack`.
- `ACQ_State` is registered and reflects the current state.

## Configuration
- Macro `SCDAQ_AUTO_TRIGGER_EN`.
- Defined:
  - A counter clears on ARMED entry and increments once per ARMED cycle.
  - On the `AUTO_TIMEOUT`-th ARMED edge without `DAQ_Trg`, a forced trigger occurs with identical trigger-edge behaviour.
  - `ACQ_Auto`<=1 on a forced trigger and <=0 on a real trigger. It holds through DONE.
- Undefined: ARMED waits indefinitely, `ACQ_Auto` is tied 0, and `AUTO_TIMEOUT` is unused.

## Structure
- Package `scdaq_pkg` holds:
  - state encodings;
  - trigger-mode constants shared with the trigger processor.
- One sub-module, `scdaq_acq_cnt`: a loadable `ADDR_WIDTH` down-counter with a zero flag. It is instanced for PRE/POST counting; a second instance counts the auto timeout when the macro is defined.

## Test plan
- `Reset_n` low for 2 cycles while in POST → `ACQ_State`=0, `BUF_We`=0, `ACQ_Done`=0, `BUF_Addr`=0, `ACQ_TrgAddr`=0.
- `ADDR_WIDTH`=4, `CFG_PRE`=3, `CFG_POST`=2, `DAQ_Trg`=1 first sampled on the 3rd ARMED edge:
  - writes to 0..7;
  - `ACQ_TrgAddr`=5;
  - `ACQ_Done`=1 one cycle after the write to 7.
- Same setup with `CFG_SINGLE`=0, `ACQ_Ack` pulsed → state PRETRIG next cycle, next write address 8. With `CFG_SINGLE`=1 → IDLE, no writes.
- wptr=14, `CFG_PRE`=4 → PRETRIG write addresses 14, 15, 0, 1, then ARMED.
- `CMD_Abort` and `DAQ_Trg`=1 on the same ARMED edge → IDLE, `ACQ_TrgAddr` unchanged, `ACQ_Done` stays 0.
- Macro defined, `AUTO_TIMEOUT`=8, `DAQ_Trg`=0 → trigger on the 8th ARMED edge and `ACQ_Auto`=1. Macro undefined → still ARMED after 100 cycles.
